// File: rtl/countdown_m.sv
// Loadable down-counter with run/hold/abort control and a one-cycle completion pulse.
// All outputs (busy, done, binary_number) are registered views of the FSM and
// count one clock late, so they stay mutually aligned: binary_number reaches 0
// in the same cycle done rises and busy falls.
module countdown_m #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] binary_number
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] bin_q;
  logic             done_q;
  logic             busy_q;

  // Loads saturate at MAX so count can never exceed it.
  logic [WIDTH-1:0] load_sat;
  assign load_sat = (load_value > MAX_C) ? MAX_C : load_value;

  // Control FSM and count register; abort beats pause beats tick while running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            // load wins over a simultaneous start
            count_q <= load_sat;
          end else if (start) begin
            state_q <= (count_q == ZERO) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            count_q <= ZERO;
            state_q <= IDLE;
          end else if (pause) begin
            state_q <= HOLD;
          end else if (tick) begin
            if (count_q == ONE) begin
              count_q <= ZERO;
              state_q <= DONE;
            end else if (count_q != ZERO) begin
              count_q <= count_q - ONE;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            count_q <= ZERO;
            state_q <= IDLE;
          end else if (start) begin
            state_q <= RUN;
          end
        end
        DONE: begin
          count_q <= ZERO;
          state_q <= IDLE;
        end
        default: begin
          count_q <= ZERO;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output registers: one-cycle-late snapshot of state and count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q  <= ZERO;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= count_q;
      done_q <= (state_q == DONE);
      busy_q <= (state_q == RUN) || (state_q == HOLD);
    end
  end

  assign binary_number = bin_q;
  assign done          = done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_countdown_m.sv
// Directed bench for countdown_m: each step pushes the hand-derived outputs
// expected after the next clock edge onto a scoreboard, which is popped and
// compared once that edge has passed.
module tb_countdown_m;

  logic       clk;
  logic       reset;
  logic       tick, load, start, pause, abort;
  logic [3:0] load_value;
  logic       busy, done;
  logic [3:0] binary_number;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] bin;
    logic       dn;
    logic       bz;
    string      tag;
  } exp_t;

  exp_t sb[$];

  countdown_m #(.WIDTH(4), .MAX(9)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .abort(abort),
    .busy(busy), .done(done), .binary_number(binary_number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] b, input logic d, input logic z);
    chk({tag, ".bin"},  binary_number, b);
    chk({tag, ".done"}, {3'b0, done},  {3'b0, d});
    chk({tag, ".busy"}, {3'b0, busy},  {3'b0, z});
  endtask

  // Push expectation, advance one edge, pop and compare, then drop pulse inputs.
  task automatic cyc(input string tag, input logic [3:0] b, input logic d, input logic z);
    exp_t e;
    e.bin = b; e.dn = d; e.bz = z; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(e.tag, e.bin, e.dn, e.bz);
    tick = 0; load = 0; start = 0; pause = 0; abort = 0;
  endtask

  initial begin
    tick = 0; load = 0; start = 0; pause = 0; abort = 0; load_value = 4'd0;
    reset = 1'b0;
    #1;
    chk_all("rst", 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 3-count run to completion
    load_value = 4'd3; load = 1;  cyc("c3.load",  4'd0, 0, 0);
    start = 1;                    cyc("c3.start", 4'd3, 0, 0);
    tick = 1;                     cyc("c3.t1",    4'd3, 0, 1);
    tick = 1;                     cyc("c3.t2",    4'd2, 0, 1);
    tick = 1;                     cyc("c3.t3",    4'd1, 0, 1);
                                  cyc("c3.done",  4'd0, 1, 0);
                                  cyc("c3.idle",  4'd0, 0, 0);

    // load saturates at MAX
    load_value = 4'd15; load = 1; cyc("sat.load", 4'd0, 0, 0);
                                  cyc("sat.val",  4'd9, 0, 0);
                                  cyc("sat.hold", 4'd9, 0, 0);

    // pause with tick, hold ignores ticks and load, resume
    load_value = 4'd5; load = 1;  cyc("ps.load",  4'd9, 0, 0);
    start = 1;                    cyc("ps.start", 4'd5, 0, 0);
    pause = 1; tick = 1;          cyc("ps.pause", 4'd5, 0, 1);
    tick = 1;                     cyc("ps.h1",    4'd5, 0, 1);
    tick = 1; load = 1; load_value = 4'd7;
                                  cyc("ps.h2",    4'd5, 0, 1);
    tick = 1;                     cyc("ps.h3",    4'd5, 0, 1);
    tick = 1;                     cyc("ps.h4",    4'd5, 0, 1);
    start = 1;                    cyc("ps.resume",4'd5, 0, 1);
    tick = 1;                     cyc("ps.t1",    4'd5, 0, 1);
    tick = 1;                     cyc("ps.t2",    4'd4, 0, 1);
    tick = 1;                     cyc("ps.t3",    4'd3, 0, 1);
    tick = 1;                     cyc("ps.t4",    4'd2, 0, 1);
    tick = 1;                     cyc("ps.t5",    4'd1, 0, 1);
                                  cyc("ps.done",  4'd0, 1, 0);
                                  cyc("ps.idle",  4'd0, 0, 0);

    // abort beats pause; no done pulse
    load_value = 4'd4; load = 1;  cyc("ab.load",  4'd0, 0, 0);
    start = 1;                    cyc("ab.start", 4'd4, 0, 0);
    abort = 1; pause = 1;         cyc("ab.abort", 4'd4, 0, 1);
                                  cyc("ab.idle1", 4'd0, 0, 0);
                                  cyc("ab.idle2", 4'd0, 0, 0);

    // start at zero goes straight to DONE; inputs ignored in DONE
    start = 1;                    cyc("z.start",  4'd0, 0, 0);
    start = 1; load = 1; load_value = 4'd5;
                                  cyc("z.done",   4'd0, 1, 0);
                                  cyc("z.idle",   4'd0, 0, 0);

    // load together with start: load only
    load_value = 4'd2; load = 1; start = 1;
                                  cyc("ls.both",  4'd0, 0, 0);
                                  cyc("ls.idle1", 4'd2, 0, 0);
                                  cyc("ls.idle2", 4'd2, 0, 0);

    // async reset mid-run at count 6
    load_value = 4'd6; load = 1;  cyc("ar.load",  4'd2, 0, 0);
    start = 1;                    cyc("ar.start", 4'd6, 0, 0);
                                  cyc("ar.run",   4'd6, 0, 1);
    #3 reset = 1'b0;
    #1 chk_all("ar.async", 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("ar.held", 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    load_value = 4'd2; load = 1;  cyc("ar.load2", 4'd0, 0, 0);
    start = 1;                    cyc("ar.start2",4'd2, 0, 0);
    tick = 1;                     cyc("ar.t1",    4'd2, 0, 1);
    tick = 1;                     cyc("ar.t2",    4'd1, 0, 1);
                                  cyc("ar.done",  4'd0, 1, 0);
                                  cyc("ar.idle",  4'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
